// File: rtl/syn_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO block.
// Read-mode selector and the sticky-flag update rule.
package syn_fifo_pkg;

   typedef enum logic [0:0] {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Sticky flag next value: a set request always beats a clear request.
   function automatic logic sticky_next(input logic set_s, input logic clr_s, input logic cur_s);
      logic nxt_s;
      if (set_s) begin
         nxt_s = 1'b1;
      end else if (clr_s) begin
         nxt_s = 1'b0;
      end else begin
         nxt_s = cur_s;
      end
      return nxt_s;
   endfunction

endpackage

// File: rtl/syn_fifo_ext_mem.sv
// FIFO storage: DEP x WID array, one synchronous write port, one asynchronous read port.
// The array is intentionally not reset; contents are qualified by the controller's count.
module fifo_mem #(
   parameter int DEP = 16,
   parameter int WID = 32
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [$clog2(DEP)-1:0] waddr,
   input  logic [WID-1:0]         wdata,
   input  logic [$clog2(DEP)-1:0] raddr,
   output logic [WID-1:0]         rdata
);

   logic [WID-1:0] mem_r [DEP];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/syn_fifo_ext.sv
// Synchronous FIFO controller with standard or first-word-fall-through read mode,
// registered occupancy/threshold flags and sticky overflow/underflow errors.
module syn_fifo_ext
   import syn_fifo_pkg::*;
#(
   parameter int         DEP   = 16,
   parameter int         WID   = 32,
   parameter fifo_mode_e MODE  = FIFO_STD,
   parameter int         AF_TH = DEP - 2,
   parameter int         AE_TH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_i,
   input  logic [WID-1:0]         wdata,
   input  logic                   rd_i,
   input  logic                   clr_err_i,
   output logic [WID-1:0]         rdata,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   almost_full_o,
   output logic                   almost_empty_o,
   output logic [$clog2(DEP):0]   count_o,
   output logic                   overflow_o,
   output logic                   underflow_o
);

   localparam int AW = $clog2(DEP);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_DEP = CW'(DEP);
   localparam logic [CW-1:0] CNT_AF = CW'(AF_TH);
   localparam logic [CW-1:0] CNT_AE = CW'(AE_TH);

   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [CW-1:0]  cnt_r;
   logic [CW-1:0]  cnt_nxt_s;
   logic           full_r;
   logic           empty_r;
   logic           af_r;
   logic           ae_r;
   logic           ovf_r;
   logic           unf_r;
   logic [WID-1:0] rdata_r;
   logic [WID-1:0] head_s;
   logic           rd_acc_s;
   logic           wr_acc_s;

   // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
   assign rd_acc_s = rd_i & ~empty_r;
   assign wr_acc_s = wr_i & (~full_r | rd_acc_s);

   fifo_mem #(
      .DEP (DEP),
      .WID (WID)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc_s),
      .waddr (wr_ptr_r),
      .wdata (wdata),
      .raddr (rd_ptr_r),
      .rdata (head_s)
   );

   // Next occupancy from the accepted-request pair.
   always_comb begin
      cnt_nxt_s = cnt_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Pointers, count and count-derived flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         cnt_r    <= CNT_ZERO;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         af_r     <= 1'b0;
         ae_r     <= 1'b1;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         cnt_r   <= cnt_nxt_s;
         full_r  <= (cnt_nxt_s == CNT_DEP);
         empty_r <= (cnt_nxt_s == CNT_ZERO);
         af_r    <= (cnt_nxt_s >= CNT_AF);
         ae_r    <= (cnt_nxt_s <= CNT_AE);
      end
   end

   // Sticky error flags and the standard-mode read register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
         rdata_r <= {WID{1'b0}};
      end else begin
         ovf_r <= sticky_next(wr_i & ~wr_acc_s, clr_err_i, ovf_r);
         unf_r <= sticky_next(rd_i & ~rd_acc_s, clr_err_i, unf_r);
         if (rd_acc_s) begin
            rdata_r <= head_s;
         end
      end
   end

   // In FWFT mode the head is forced to zero while empty so reset presents a defined value.
   assign rdata          = (MODE == FIFO_FWFT) ? (empty_r ? {WID{1'b0}} : head_s) : rdata_r;
   assign full_o         = full_r;
   assign empty_o        = empty_r;
   assign almost_full_o  = af_r;
   assign almost_empty_o = ae_r;
   assign count_o        = cnt_r;
   assign overflow_o     = ovf_r;
   assign underflow_o    = unf_r;

endmodule

// File: tb/tb_syn_fifo_ext.sv
// Scoreboard bench: a STD and an FWFT instance share stimulus; a queue model predicts
// flags and data, and a monitor pops expected STD read data one cycle after each accepted read.
module tb_syn_fifo_ext;
   import syn_fifo_pkg::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] wdata = 32'h0;

   logic [31:0] rdata_std, rdata_fw;
   logic        full_std, empty_std, af_std, ae_std, ovf_std, unf_std;
   logic        full_fw, empty_fw, af_fw, ae_fw, ovf_fw, unf_fw;
   logic [3:0]  cnt_std, cnt_fw;

   int tests = 0;
   int fails = 0;

   logic [31:0] mq[$];
   logic [31:0] exp_q[$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;

   always #5 clk = ~clk;

   syn_fifo_ext #(.DEP(D), .WID(32), .MODE(FIFO_STD), .AF_TH(6), .AE_TH(2)) u_std (
      .clk(clk), .rst(rst), .wr_i(wr), .wdata(wdata), .rd_i(rd), .clr_err_i(clr),
      .rdata(rdata_std), .full_o(full_std), .empty_o(empty_std), .almost_full_o(af_std),
      .almost_empty_o(ae_std), .count_o(cnt_std), .overflow_o(ovf_std), .underflow_o(unf_std));

   syn_fifo_ext #(.DEP(D), .WID(32), .MODE(FIFO_FWFT), .AF_TH(6), .AE_TH(2)) u_fwft (
      .clk(clk), .rst(rst), .wr_i(wr), .wdata(wdata), .rd_i(rd), .clr_err_i(clr),
      .rdata(rdata_fw), .full_o(full_fw), .empty_o(empty_fw), .almost_full_o(af_fw),
      .almost_empty_o(ae_fw), .count_o(cnt_fw), .overflow_o(ovf_fw), .underflow_o(unf_fw));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int sz;
      sz = mq.size();
      chk("count", {28'h0, cnt_std}, sz);
      chk("full", {31'h0, full_std}, {31'h0, sz == D});
      chk("empty", {31'h0, empty_std}, {31'h0, sz == 0});
      chk("almost_full", {31'h0, af_std}, {31'h0, sz >= 6});
      chk("almost_empty", {31'h0, ae_std}, {31'h0, sz <= 2});
      chk("overflow", {31'h0, ovf_std}, {31'h0, m_ovf});
      chk("underflow", {31'h0, unf_std}, {31'h0, m_unf});
      chk("fwft_count", {28'h0, cnt_fw}, sz);
      chk("fwft_empty", {31'h0, empty_fw}, {31'h0, sz == 0});
      if (sz > 0) begin
         chk("fwft_head", rdata_fw, mq[0]);
      end
   endtask

   // One clock of stimulus; the model follows the accept rules on the sampling edge.
   task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic c);
      logic ra, wa;
      wr = w; wdata = d; rd = r; clr = c;
      @(negedge clk);
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < D) || ra);
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && !ra) ? 1'b1 : (c ? 1'b0 : m_unf);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"}, {28'h0, cnt_std}, 32'd0);
      chk({tag, "_empty"}, {31'h0, empty_std}, 32'd1);
      chk({tag, "_almost_empty"}, {31'h0, ae_std}, 32'd1);
      chk({tag, "_full"}, {31'h0, full_std}, 32'd0);
      chk({tag, "_almost_full"}, {31'h0, af_std}, 32'd0);
      chk({tag, "_overflow"}, {31'h0, ovf_std}, 32'd0);
      chk({tag, "_underflow"}, {31'h0, unf_std}, 32'd0);
      chk({tag, "_rdata_std"}, rdata_std, 32'd0);
      chk({tag, "_rdata_fwft"}, rdata_fw, 32'd0);
      chk({tag, "_fwft_count"}, {28'h0, cnt_fw}, 32'd0);
   endtask

   task automatic monitor();
      logic        pend;
      logic [31:0] e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL std_rdata: got %h but no read was expected", rdata_std);
            end else begin
               e = exp_q.pop_front();
               chk("std_rdata", rdata_std, e);
            end
         end
         pend = rd && !empty_std && !rst;
      end
   endtask

   task automatic run_all();
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Fill to full, overflow, clear, then drain in order.
      for (int i = 1; i <= 8; i++) cyc(1'b1, 32'h11 * i, 1'b0, 1'b0);
      cyc(1'b1, 32'h99, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);

      // First-word-fall-through visibility.
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);

      // Full with simultaneous write and read across pointer wrap.
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 32'h200 + i, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

      // Underflow and clear priority.
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b1, 32'h777, 1'b1, 1'b0);

      // Asynchronous reset with five words held.
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h50 + i, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_reset_count", {28'h0, cnt_std}, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b1, 32'h42, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 5),
             ($urandom_range(0, 15) == 0));
      end

      n = 0;
      while ((mq.size() > 0) && (n < 20)) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
         n++;
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      fork
         run_all();
         monitor();
         begin
            #200000;
            tests++;
            fails++;
            $display("FAIL watchdog: time limit reached");
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/syn_fifo_ext.md
SYN_FIFO_EXT -- requirements
Module: syn_fifo_ext

Interface
REQ-001 SHALL have parameter DEP, default 16, depth in words; power of two, >= 4.
REQ-002 SHALL have parameter WID, default 32, data width in bits.
REQ-003 SHALL have parameter MODE, default FIFO_STD, read mode: FIFO_STD or FIFO_FWFT.
REQ-004 SHALL have parameter AF_TH, default DEP-2, almost-full threshold in words.
REQ-005 SHALL have parameter AE_TH, default 2, almost-empty threshold in words.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port wr_i  input  1  write request.
REQ-009 SHALL have port wdata  input  WID  write data.
REQ-010 SHALL have port rd_i  input  1  read (STD) / pop (FWFT) request.
REQ-011 SHALL have port clr_err_i  input  1  clears sticky error flags.
REQ-012 SHALL have port rdata  output  WID  read data.
REQ-013 SHALL have port full_o  output  1  count == DEP.
REQ-014 SHALL have port empty_o  output  1  count == 0.
REQ-015 SHALL have port almost_full_o  output  1  count >= AF_TH.
REQ-016 SHALL have port almost_empty_o  output  1  count <= AE_TH.
REQ-017 SHALL have port count_o  output  $clog2(DEP)+1  occupancy, 0..DEP.
REQ-018 SHALL have port overflow_o  output  1  sticky: write rejected.
REQ-019 SHALL have port underflow_o  output  1  sticky: read rejected.

Function
REQ-020 Read accepted iff rd_i && !empty_o; write accepted iff wr_i && (!full_o || read accepted this cycle).
REQ-021 Full with wr_i and rd_i: both accepted, count unchanged, pointers both advance.
REQ-022 Empty with wr_i and rd_i: write accepted, read rejected, underflow_o set.
REQ-023 Pointers $clog2(DEP) bits, wrap DEP-1 -> 0 without gap; count register is the single source of all status flags.
REQ-024 All flags and count_o SHALL reflect the state after the previous edge (registered, no combinational path from wr_i/rd_i).
REQ-025 FIFO_STD: rdata loads head word on the edge a read is accepted (1-cycle latency) and holds until next accepted read.
REQ-026 FIFO_FWFT: rdata shows head word whenever !empty_o, zero-latency; a write into empty FIFO is visible on rdata the cycle after the write edge; value when empty_o is don't-care.
REQ-027 overflow_o sets on a rejected write, underflow_o on a rejected read; both hold until clr_err_i; set and clear in the same cycle -> set wins.
REQ-028 Rejected requests SHALL not alter memory, pointers or count.

Reset
REQ-029 rst SHALL asynchronously force: pointers 0, count_o 0, empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0, overflow_o 0, underflow_o 0, rdata 0.
REQ-030 Reset mid-operation discards contents; memory array is not reset; first post-reset write lands at address 0.

Structure
REQ-031 Package syn_fifo_pkg SHALL hold enum fifo_mode_e {FIFO_STD, FIFO_FWFT}.
REQ-032 Storage SHALL be sub-module fifo_mem (DEP x WID, one synchronous write port, one asynchronous read port); control in syn_fifo_ext.

Verification (DEP=8, WID=32, AF_TH=6, AE_TH=2)
REQ-033 STD: write 0x11..0x88 (8 words) -> full_o=1, count_o=8, almost_full_o from count 6; 9th write 0x99 -> overflow_o=1, contents unchanged; 8 reads return 0x11..0x88 in order, each one cycle after accept.
REQ-034 FWFT: single write 0xDEADBEEF into empty -> next cycle empty_o=0, rdata=0xDEADBEEF with no rd_i; rd_i one cycle -> empty_o=1.
REQ-035 Full + simultaneous wr_i/rd_i for 20 cycles with incrementing data -> count_o stays 8, no overflow, read order matches write order across pointer wrap.
REQ-036 Empty + rd_i -> underflow_o=1; clr_err_i pulse -> 0; clr_err_i with concurrent rejected read -> stays 1.
REQ-037 Assert rst while count_o=5 -> outputs take REQ-029 values asynchronously; next write 0x42 then read returns 0x42.
